// File: rtl/a23_drain_pkg.sv
// Shared types and constants for the A23 output-drain stage.
// Optional watchdog is enabled with the A23_DRAIN_TIMEOUT_EN macro.
package a23_drain_pkg;

   localparam int A23_WORD_W       = 32;
   localparam int A23_OUT_MEM_SIZE = 64;
   localparam int A23_CC_WIDTH     = 32;
   localparam int A23_TIMEOUT_CC   = 100000;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_STREAM = 2'd1,
      ST_DONE   = 2'd2
   } drain_state_t;

endpackage

// File: rtl/a23_drain_cc_counter.sv
// Saturating clear/enable cycle counter for the A23 output drain.
// With A23_DRAIN_TIMEOUT_EN defined it also flags when the count reaches TIMEOUT_CC.
module a23_drain_cc_counter
   import a23_drain_pkg::*;
#(
   parameter int CC_WIDTH = A23_CC_WIDTH
`ifdef A23_DRAIN_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CC = A23_TIMEOUT_CC
`endif
) (
   input  logic                i_clk,
   input  logic                i_clr,
   input  logic                i_en,
   output logic [CC_WIDTH-1:0] o_count
`ifdef A23_DRAIN_TIMEOUT_EN
   ,
   output logic                o_at_limit
`endif
);

   logic [CC_WIDTH-1:0] r_count;
   logic                w_sat;

   assign w_sat   = &r_count;
   assign o_count = r_count;

   always_ff @(posedge i_clk) begin
      if (i_clr)
         r_count <= '0;
      else if (i_en && !w_sat)
         r_count <= r_count + CC_WIDTH'(1);
   end

`ifdef A23_DRAIN_TIMEOUT_EN
   // Compare in 64 bits so a limit wider than the counter simply never fires.
   localparam logic [63:0] LIMIT = 64'(TIMEOUT_CC);
   assign o_at_limit = (64'(r_count) >= LIMIT);
`endif

endmodule

// File: rtl/a23_out_drain.sv
// Captures the A23 core's output memory on terminate and streams it out word by word.
// Optional cycle watchdog is enabled with the A23_DRAIN_TIMEOUT_EN macro.
module a23_out_drain
   import a23_drain_pkg::*;
#(
   parameter int OUT_MEM_SIZE = A23_OUT_MEM_SIZE,
   parameter int CC_WIDTH     = A23_CC_WIDTH,
   parameter int TIMEOUT_CC   = A23_TIMEOUT_CC
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [OUT_MEM_SIZE*A23_WORD_W-1:0] o,
   input  logic                               terminate,
   output logic [A23_WORD_W-1:0]              out_data,
   output logic [$clog2(OUT_MEM_SIZE)-1:0]    out_index,
   output logic                               out_valid,
   input  logic                               out_ready,
   output logic                               out_last,
   output logic [CC_WIDTH-1:0]                cc_count,
   output logic                               done
`ifdef A23_DRAIN_TIMEOUT_EN
   ,
   output logic                               timeout
`endif
);

   localparam int                IDX_W    = $clog2(OUT_MEM_SIZE);
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(OUT_MEM_SIZE - 1);

   if (OUT_MEM_SIZE < 2 || TIMEOUT_CC < 1) begin : g_param_err
      $error("a23_out_drain: OUT_MEM_SIZE must be >= 2 and TIMEOUT_CC >= 1");
   end

   drain_state_t          r_state, w_state_nxt;
   logic [A23_WORD_W-1:0] r_buf [OUT_MEM_SIZE];
   logic [A23_WORD_W-1:0] r_out_data;
   logic [IDX_W-1:0]      r_out_index;
   logic [IDX_W-1:0]      w_idx_inc;
   logic                  r_out_valid;
   logic                  r_out_last;
   logic                  r_done;
   logic                  w_capture;
   logic                  w_wd_capture;
   logic                  w_hs;
   logic                  w_cnt_en;
`ifdef A23_DRAIN_TIMEOUT_EN
   logic                  w_at_limit;
   logic                  r_timeout;
`endif

   assign w_hs      = r_out_valid && out_ready;
   assign w_idx_inc = r_out_index + IDX_W'(1);
   assign w_cnt_en  = (r_state == ST_RUN) && !w_capture;

   a23_drain_cc_counter #(
      .CC_WIDTH   (CC_WIDTH)
`ifdef A23_DRAIN_TIMEOUT_EN
      ,
      .TIMEOUT_CC (TIMEOUT_CC)
`endif
   ) u_cc (
      .i_clk      (clk),
      .i_clr      (rst),
      .i_en       (w_cnt_en),
      .o_count    (cc_count)
`ifdef A23_DRAIN_TIMEOUT_EN
      ,
      .o_at_limit (w_at_limit)
`endif
   );

   always_ff @(posedge clk) begin
      if (rst)
         r_state <= ST_RUN;
      else
         r_state <= w_state_nxt;
   end

   // A real terminate takes priority over the watchdog in the same cycle.
   always_comb begin
      w_state_nxt  = r_state;
      w_capture    = 1'b0;
      w_wd_capture = 1'b0;
      case (r_state)
         ST_RUN: begin
            if (terminate) begin
               w_capture   = 1'b1;
               w_state_nxt = ST_STREAM;
            end
`ifdef A23_DRAIN_TIMEOUT_EN
            else if (w_at_limit) begin
               w_capture    = 1'b1;
               w_wd_capture = 1'b1;
               w_state_nxt  = ST_STREAM;
            end
`endif
         end
         ST_STREAM: begin
            if (w_hs && r_out_last)
               w_state_nxt = ST_DONE;
         end
         ST_DONE:  w_state_nxt = ST_DONE;
         default:  w_state_nxt = ST_RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_data  <= '0;
         r_out_index <= '0;
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
         r_done      <= 1'b0;
`ifdef A23_DRAIN_TIMEOUT_EN
         r_timeout   <= 1'b0;
`endif
      end else if (w_capture) begin
         r_out_data  <= o[A23_WORD_W-1:0];
         r_out_index <= '0;
         r_out_valid <= 1'b1;
         r_out_last  <= 1'b0;
`ifdef A23_DRAIN_TIMEOUT_EN
         r_timeout   <= w_wd_capture;
`endif
      end else if (w_hs) begin
         if (r_out_last) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_done      <= 1'b1;
         end else begin
            r_out_index <= w_idx_inc;
            r_out_data  <= r_buf[w_idx_inc];
            r_out_last  <= (w_idx_inc == LAST_IDX);
         end
      end
   end

   // Snapshot buffer is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (w_capture) begin
         for (int i = 0; i < OUT_MEM_SIZE; i++)
            r_buf[i] <= o[A23_WORD_W*i +: A23_WORD_W];
      end
   end

   assign out_data  = r_out_data;
   assign out_index = r_out_index;
   assign out_valid = r_out_valid;
   assign out_last  = r_out_last;
   assign done      = r_done;
`ifdef A23_DRAIN_TIMEOUT_EN
   assign timeout   = r_timeout;
`endif

endmodule
